ddr4_avl_arbiter: RTL

DDR4_AVL_ARBITER -- requirements
Module: ddr4_avl_arbiter

---
 rtl/ddr4_avl_arbiter_pkg.sv | 29 ++
 rtl/ddr4_tag_fifo.sv | 57 +++++
 rtl/ddr4_avl_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ddr4_avl_arbiter_pkg.sv
// Shared types and constants for the two-client DDR4 Avalon arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr4_avl_arbiter_pkg;

  localparam int AVL_ADDR_W = 26;
  localparam int AVL_DATA_W = 512;
  localparam int AVL_BE_W   = 64;
  localparam int AVL_SIZE_W = 7;
  localparam int MAX_BURST  = 64;

  // Beat counters only ever hold size-1, so 0..MAX_BURST-1 suffices.
  localparam int CNT_W = $clog2(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2
  } arb_state_e;

  // One entry per outstanding read burst: who asked and how many beats.
  typedef struct packed {
    logic                  client;
    logic [AVL_SIZE_W-1:0] size;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/ddr4_tag_fifo.sv
// Synchronous FIFO of outstanding read tags; head is visible combinationally.
// Latency: push visible at head one cycle later; pop takes effect on the edge.
// Backpressure: full/empty flags; push while full is dropped unless a pop frees a slot that cycle.
module ddr4_tag_fifo
  import ddr4_avl_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             sync_clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  logic             pop_i,
  output logic [TAG_W-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  // Storage array: written on push, no reset needed since count gates validity.
  always_ff @(posedge sync_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge sync_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr4_avl_arbiter.sv
// Round-robin arbiter of two clients onto one DDR4 Avalon port, with in-order read return.
// Latency: request on avl_* one cycle after cmd_ack; read beat on rd_* one cycle after avl_rdata_valid.
// Backpressure: avl_ready=0 freezes all avl_* outputs; reads stall at grant while the tag FIFO is full.
module ddr4_avl_arbiter
  import ddr4_avl_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH = 8
) (
  input  logic                    sync_clk,
  input  logic                    reset_n,
  input  logic [1:0]              cmd_valid,
  input  logic [1:0]              cmd_write,
  input  logic [2*AVL_ADDR_W-1:0] cmd_addr,
  input  logic [2*AVL_SIZE_W-1:0] cmd_size,
  output logic [1:0]              cmd_ack,
  input  logic [2*AVL_DATA_W-1:0] wdata,
  input  logic [2*AVL_BE_W-1:0]   wbe,
  output logic [1:0]              wbeat_ack,
  output logic [1:0]              rd_valid,
  output logic [AVL_DATA_W-1:0]   rd_data,
  output logic                    err_unexp_rdata,
  input  logic                    avl_ready,
  input  logic                    avl_rdata_valid,
  input  logic [AVL_DATA_W-1:0]   avl_rdata,
  output logic [AVL_ADDR_W-1:0]   avl_addr,
  output logic [AVL_DATA_W-1:0]   avl_wdata,
  output logic [AVL_BE_W-1:0]     avl_be,
  output logic                    avl_read_req,
  output logic                    avl_write_req,
  output logic [AVL_SIZE_W-1:0]   avl_size
);

  arb_state_e            state_q;
  logic                  rr_q;        // client granted last
  logic                  gnt_q;       // client owning the current burst
  logic [CNT_W-1:0]      cnt_q;       // write beats remaining after the one on the bus
  logic [AVL_ADDR_W-1:0] avl_addr_q;
  logic [AVL_DATA_W-1:0] avl_wdata_q;
  logic [AVL_BE_W-1:0]   avl_be_q;
  logic [AVL_SIZE_W-1:0] avl_size_q;
  logic                  avl_read_q;
  logic                  avl_write_q;

  logic [1:0]            rd_valid_q;
  logic [AVL_DATA_W-1:0] rd_data_q;
  logic                  err_q;
  logic [CNT_W-1:0]      rcnt_q;
  logic [CNT_W-1:0]      rcnt_d;

  logic [1:0]            elig;
  logic                  gnt;
  logic                  gnt_any;
  logic                  cur_cl;
  logic                  sel_write;
  logic [AVL_ADDR_W-1:0] sel_addr;
  logic [AVL_SIZE_W-1:0] sel_size;
  logic [AVL_DATA_W-1:0] sel_wdata;
  logic [AVL_BE_W-1:0]   sel_be;
  logic                  lat_wr;
  logic                  burst_adv;

  logic                  tag_push;
  logic                  tag_pop;
  logic                  tag_full;
  logic                  tag_empty;
  logic [TAG_W-1:0]      head_raw;
  tag_t                  head;
  logic                  rd_hit;
  logic                  rd_last;

  // Eligibility and round-robin pick; a lone eligible client wins regardless of rr_q.
  always_comb begin
    elig    = cmd_valid & (cmd_write | {2{~tag_full}});
    gnt     = (elig == 2'b11) ? ~rr_q : elig[1];
    gnt_any = (state_q == IDLE) && (elig != 2'b00);
    cur_cl  = (state_q == IDLE) ? gnt : gnt_q;
  end

  assign sel_write = gnt ? cmd_write[1] : cmd_write[0];
  assign sel_addr  = gnt ? cmd_addr[2*AVL_ADDR_W-1:AVL_ADDR_W] : cmd_addr[AVL_ADDR_W-1:0];
  assign sel_size  = gnt ? cmd_size[2*AVL_SIZE_W-1:AVL_SIZE_W] : cmd_size[AVL_SIZE_W-1:0];
  assign sel_wdata = cur_cl ? wdata[2*AVL_DATA_W-1:AVL_DATA_W] : wdata[AVL_DATA_W-1:0];
  assign sel_be    = cur_cl ? wbe[2*AVL_BE_W-1:AVL_BE_W] : wbe[AVL_BE_W-1:0];

  // A write beat is consumed at the grant (beat 0) and on every accepted non-final beat.
  assign lat_wr    = gnt_any && sel_write && (sel_size != '0);
  assign burst_adv = (state_q == WR_BURST) && avl_ready && (cnt_q != '0);

  // Acks are same-cycle handshakes; gating with reset_n keeps them low while in reset.
  assign cmd_ack   = (reset_n && gnt_any) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign wbeat_ack = (reset_n && (lat_wr || burst_adv)) ? (cur_cl ? 2'b10 : 2'b01) : 2'b00;

  // Command FSM: owns every avl_* register so outputs only move on accept or grant.
  always_ff @(posedge sync_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b1;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      avl_addr_q  <= '0;
      avl_wdata_q <= '0;
      avl_be_q    <= '0;
      avl_size_q  <= '0;
      avl_read_q  <= 1'b0;
      avl_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            rr_q  <= gnt;
            gnt_q <= gnt;
            // Zero-length commands are acked and discarded here.
            if (sel_size != '0) begin
              avl_addr_q <= sel_addr;
              avl_size_q <= sel_size;
              if (sel_write) begin
                avl_wdata_q <= sel_wdata;
                avl_be_q    <= sel_be;
                avl_write_q <= 1'b1;
                cnt_q       <= CNT_W'(sel_size - 1'b1);
                state_q     <= WR_BURST;
              end else begin
                avl_read_q <= 1'b1;
                state_q    <= RD_CMD;
              end
            end
          end
        end
        WR_BURST: begin
          if (avl_ready) begin
            if (cnt_q != '0) begin
              avl_wdata_q <= sel_wdata;
              avl_be_q    <= sel_be;
              cnt_q       <= cnt_q - 1'b1;
            end else begin
              avl_write_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        RD_CMD: begin
          if (avl_ready) begin
            avl_read_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avl_addr      = avl_addr_q;
  assign avl_wdata     = avl_wdata_q;
  assign avl_be        = avl_be_q;
  assign avl_size      = avl_size_q;
  assign avl_read_req  = avl_read_q;
  assign avl_write_req = avl_write_q;

  // A read command becomes outstanding only once DDR has accepted it.
  assign tag_push = (state_q == RD_CMD) && avl_ready;

  ddr4_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .sync_clk   (sync_clk),
    .reset_n    (reset_n),
    .push_i     (tag_push),
    .push_tag_i ({gnt_q, avl_size_q}),
    .pop_i      (tag_pop),
    .head_o     (head_raw),
    .full_o     (tag_full),
    .empty_o    (tag_empty)
  );

  assign head    = tag_t'(head_raw);
  assign rd_hit  = avl_rdata_valid && !tag_empty;
  assign rd_last = rd_hit && (rcnt_q == CNT_W'(head.size - 1'b1));
  assign tag_pop = rd_last;

  // Head beat counter: advances per returned beat, clears when the burst completes.
  always_comb begin
    rcnt_d = rcnt_q;
    if (rd_hit) rcnt_d = rd_last ? '0 : rcnt_q + 1'b1;
  end

  // Read return path: route each beat to the head's client; flag beats nobody asked for.
  always_ff @(posedge sync_clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_q     <= '0;
      rd_valid_q <= 2'b00;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      rcnt_q     <= rcnt_d;
      rd_valid_q <= rd_hit ? (head.client ? 2'b10 : 2'b01) : 2'b00;
      if (avl_rdata_valid)              rd_data_q <= avl_rdata;
      if (avl_rdata_valid && tag_empty) err_q     <= 1'b1;
    end
  end

  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign err_unexp_rdata = err_q;

endmodule
